// File: rtl/implication_monitor.sv
// Run-time checker for "A implies C exactly DELAY cycles later".
// Reports violations as a pulse, a sticky error, saturating counters and a first-failure timestamp.
module implication_monitor #(
  parameter int DELAY     = 1,
  parameter int CNT_WIDTH = 8,
  parameter int TS_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESET,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic                 A,
  input  logic                 C,
  output logic                 FAIL,
  output logic                 ERR,
  output logic [CNT_WIDTH-1:0] FAIL_COUNT,
  output logic [CNT_WIDTH-1:0] PASS_COUNT,
  output logic [TS_WIDTH-1:0]  FIRST_FAIL_TS,
  output logic                 PENDING
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TS_WIDTH-1:0]  TS_ONE  = TS_WIDTH'(1);

  logic [DELAY-1:0]    pend;
  logic [DELAY-1:0]    pend_next;
  logic [TS_WIDTH-1:0] ts;
  logic                mature;
  logic                miss;
  logic                hit;

  // Each bit of pend is one obligation, aged by one position per cycle.
  always_comb begin
    pend_next    = '0;
    pend_next[0] = EN & A;
    for (int i = 1; i < DELAY; i++) begin
      pend_next[i] = pend[i-1];
    end
  end

  assign mature = pend[DELAY-1];
  assign miss   = mature & ~C;
  assign hit    = mature & C;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      pend    <= '0;
      ts      <= '0;
      PENDING <= 1'b0;
    end else if (CLR) begin
      pend    <= '0;
      ts      <= '0;
      PENDING <= 1'b0;
    end else begin
      pend    <= pend_next;
      ts      <= ts + TS_ONE;
      PENDING <= |pend_next;
    end
  end

  // FIRST_FAIL_TS latches the pre-increment timestamp only on the first miss.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      FAIL          <= 1'b0;
      ERR           <= 1'b0;
      FAIL_COUNT    <= '0;
      FIRST_FAIL_TS <= '0;
    end else if (CLR) begin
      FAIL          <= 1'b0;
      ERR           <= 1'b0;
      FAIL_COUNT    <= '0;
      FIRST_FAIL_TS <= '0;
    end else begin
      FAIL <= miss;
      if (miss) begin
        if (FAIL_COUNT != CNT_MAX) begin
          FAIL_COUNT <= FAIL_COUNT + CNT_ONE;
        end
        if (!ERR) begin
          ERR           <= 1'b1;
          FIRST_FAIL_TS <= ts;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      PASS_COUNT <= '0;
    end else if (CLR) begin
      PASS_COUNT <= '0;
    end else if (hit && (PASS_COUNT != CNT_MAX)) begin
      PASS_COUNT <= PASS_COUNT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_implication_monitor.sv
// Scoreboard bench for implication_monitor: a queue-of-deadlines reference model
// pushes expected outputs per edge, a negedge monitor pops and compares them.
module tb_implication_monitor;

  localparam int DELAY     = 3;
  localparam int CNT_WIDTH = 3;
  localparam int TS_WIDTH  = 6;
  localparam int CMAX      = (1 << CNT_WIDTH) - 1;

  logic                 CLK;
  logic                 ASYNCRESET;
  logic                 EN;
  logic                 CLR;
  logic                 A;
  logic                 C;
  logic                 FAIL;
  logic                 ERR;
  logic [CNT_WIDTH-1:0] FAIL_COUNT;
  logic [CNT_WIDTH-1:0] PASS_COUNT;
  logic [TS_WIDTH-1:0]  FIRST_FAIL_TS;
  logic                 PENDING;

  implication_monitor #(
    .DELAY(DELAY),
    .CNT_WIDTH(CNT_WIDTH),
    .TS_WIDTH(TS_WIDTH)
  ) dut (
    .CLK(CLK),
    .ASYNCRESET(ASYNCRESET),
    .EN(EN),
    .CLR(CLR),
    .A(A),
    .C(C),
    .FAIL(FAIL),
    .ERR(ERR),
    .FAIL_COUNT(FAIL_COUNT),
    .PASS_COUNT(PASS_COUNT),
    .FIRST_FAIL_TS(FIRST_FAIL_TS),
    .PENDING(PENDING)
  );

  typedef struct {
    int fail;
    int err;
    int fail_count;
    int pass_count;
    int first_ts;
    int pending;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: absolute edge number plus a list of due edges per obligation.
  int m_edge;
  int m_due[$];
  int m_fail;
  int m_err;
  int m_fc;
  int m_pc;
  int m_fts;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_output(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_due.delete();
    m_fail = 0;
    m_err  = 0;
    m_fc   = 0;
    m_pc   = 0;
    m_fts  = 0;
  endtask

  task automatic model_edge(input int en, input int a, input int c, input int clr);
    int ts_now;
    ts_now = m_edge % (1 << TS_WIDTH);
    if (clr != 0) begin
      model_reset();
    end else begin
      m_fail = 0;
      if (m_due.size() > 0 && m_due[0] == m_edge) begin
        void'(m_due.pop_front());
        if (c != 0) begin
          if (m_pc < CMAX) m_pc++;
        end else begin
          m_fail = 1;
          if (m_fc < CMAX) m_fc++;
          if (m_err == 0) begin
            m_err = 1;
            m_fts = ts_now;
          end
        end
      end
      if (en != 0 && a != 0) m_due.push_back(m_edge + DELAY);
      m_edge++;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.fail       = m_fail;
    e.err        = m_err;
    e.fail_count = m_fc;
    e.pass_count = m_pc;
    e.first_ts   = m_fts;
    e.pending    = (m_due.size() > 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input int en, input int a, input int c, input int clr);
    EN  = 1'(en);
    A   = 1'(a);
    C   = 1'(c);
    CLR = 1'(clr);
    model_edge(en, a, c, clr);
    @(posedge CLK);
    push_expected();
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, "_fail"}, int'(FAIL), 0);
    check_output({tag, "_err"}, int'(ERR), 0);
    check_output({tag, "_fail_count"}, int'(FAIL_COUNT), 0);
    check_output({tag, "_pass_count"}, int'(PASS_COUNT), 0);
    check_output({tag, "_first_ts"}, int'(FIRST_FAIL_TS), 0);
    check_output({tag, "_pending"}, int'(PENDING), 0);
  endtask

  // Reset is raised between edges so its effect is visible before any clock.
  task automatic async_reset();
    @(negedge CLK);
    #1;
    ASYNCRESET = 1'b1;
    EN = 1'b0;
    A = 1'b0;
    C = 1'b0;
    CLR = 1'b0;
    model_reset();
    #1;
    check_zero("async");
    @(posedge CLK);
    push_expected();
    #1;
    ASYNCRESET = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("fail_pulse", int'(FAIL), e.fail);
        check_output("err", int'(ERR), e.err);
        check_output("fail_count", int'(FAIL_COUNT), e.fail_count);
        check_output("pass_count", int'(PASS_COUNT), e.pass_count);
        check_output("first_fail_ts", int'(FIRST_FAIL_TS), e.first_ts);
        check_output("pending", int'(PENDING), e.pending);
      end
    end
  end

  initial begin : stimulus
    ASYNCRESET = 1'b1;
    EN = 1'b0;
    A = 1'b0;
    C = 1'b0;
    CLR = 1'b0;
    model_reset();
    #3;
    check_zero("reset");
    @(posedge CLK);
    push_expected();
    #1;
    ASYNCRESET = 1'b0;

    // Three back-to-back obligations answered with C=1,0,1.
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 1, 0);
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 1, 0);

    // EN gating: only the first A becomes an obligation.
    apply_stimulus(1, 1, 1, 0);
    apply_stimulus(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0);

    // Continuous misses drive FAIL_COUNT into saturation, then CLR on a miss edge.
    for (int i = 0; i < 12; i++) apply_stimulus(1, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0);

    // Idle long enough for the timestamp to wrap before the first miss.
    for (int i = 0; i < 70; i++) apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0);

    // Asynchronous reset with two obligations in flight.
    apply_stimulus(1, 1, 1, 0);
    apply_stimulus(1, 1, 1, 0);
    async_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        apply_stimulus(($urandom_range(0, 3) != 0) ? 1 : 0,
                       int'($urandom_range(0, 1)),
                       ($urandom_range(0, 2) != 0) ? 1 : 0,
                       ($urandom_range(0, 59) == 0) ? 1 : 0);
      end
    end

    repeat (3) @(negedge CLK);
    check_output("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/implication_monitor.md
# implication_monitor

Synthesizable run-time checker for the property "A implies C exactly DELAY cycles later", clocked by CLK. It is the hardware-resident counterpart of the simulation-only bound assertion modules: it observes a design's antecedent/consequent signals and reports violations, counts and a failure timestamp as registered outputs. The block is instantiated beside a registered datapath and wired to the same signals an assertion would watch. Its outputs are readable in silicon or in emulation.

## Interface
Parameters:
- DELAY, 1, cycles between antecedent sample and consequent check; legal 1..8. With DELAY=1 the block checks A |-> ##1 C.
- CNT_WIDTH, 8, width of FAIL_COUNT and PASS_COUNT; both counters saturate.
- TS_WIDTH, 16, width of the free-running cycle timestamp.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- EN  input  1  when 1, A is sampled as a new obligation; when 0, no new obligation enters.
- CLR  input  1  synchronous clear of status, counters, timestamp and in-flight obligations.
- A  input  1  antecedent.
- C  input  1  consequent.
- FAIL  output  1  registered one-cycle pulse per failed obligation.
- ERR  output  1  sticky; set on the first failure.
- FAIL_COUNT  output  CNT_WIDTH  saturating count of failed obligations.
- PASS_COUNT  output  CNT_WIDTH  saturating count of obligations that matured with C=1.
- FIRST_FAIL_TS  output  TS_WIDTH  timestamp of the first failure; valid while ERR=1.
- PENDING  output  1  1 while any obligation is in flight.

## Operation
- Obligation pipeline: a DELAY-bit shift register `pend`. On each edge, `pend[0] <= EN & A` and `pend[i] <= pend[i-1]`.
- An obligation matures in the cycle where `pend[DELAY-1]=1`.
  - In that cycle, `miss = ~C` and `hit = C`. C is sampled at the same edge that shifts `pend`.
  - Each matured obligation is checked independently. Back-to-back A cycles create back-to-back obligations.
- Deasserting EN stops new obligations only. Obligations already in flight still mature and are checked.
- Timestamp TS: free-running TS_WIDTH counter, +1 every edge, wraps from all-ones to 0. It is internal; only its captured value is exported.
- On a miss edge:
  - FAIL <= 1.
  - FAIL_COUNT <= FAIL_COUNT+1, unless it is all-ones.
  - If ERR=0: ERR <= 1 and FIRST_FAIL_TS <= TS, using the value before increment. Later misses do not change FIRST_FAIL_TS.
- On a hit edge: PASS_COUNT <= PASS_COUNT+1, unless it is all-ones. FAIL <= 0.
- No maturing obligation: FAIL <= 0 and the counters hold.
- PENDING is registered as the OR of the next value of `pend`.
- CLR (synchronous) takes priority over every other update:
  - `pend`, TS, ERR, FAIL, FAIL_COUNT, PASS_COUNT, FIRST_FAIL_TS all become 0.
  - A miss maturing on the CLR edge is discarded.
  - A sampled on the CLR edge is discarded.
- ASYNCRESET has the same effect as CLR but acts immediately, without waiting for a clock edge.

## Timing
- Reset values: FAIL=0, ERR=0, FAIL_COUNT=0, PASS_COUNT=0, FIRST_FAIL_TS=0, PENDING=0, and internally TS=0, pend=0.
- A sampled at edge k (EN=1) is checked against C sampled at edge k+DELAY.
- FAIL is high from edge k+DELAY to edge k+DELAY+1. ERR and the counters update at the same edge.
- Latency from the violating C value to FAIL is 1 edge. There is no combinational path from any input to any output.
- PENDING rises at edge k. It falls at edge k+DELAY if no newer obligation is in flight.
- Reset mid-operation: all in-flight obligations are lost and no FAIL is emitted for them.
- Deassertion of ASYNCRESET is synchronized externally; the block does not resynchronize it.
- Maximum obligation rate: one per cycle. The pipeline never overflows because depth equals DELAY.

## Test plan
- DELAY=1. A=1 at edge 3, C=1 at edge 4 → FAIL stays 0, PASS_COUNT=1 after edge 4, ERR=0, PENDING high only between edges 3 and 4.
- DELAY=1. A=1 at edge 5 (TS=5), C=0 at edge 6 → FAIL pulses between edges 6 and 7, ERR=1, FAIL_COUNT=1, FIRST_FAIL_TS=6. A second miss at edge 10 → FAIL_COUNT=2, FIRST_FAIL_TS still 6.
- DELAY=3. A=1 on edges 2, 3, 4; C=1,0,1 on edges 5, 6, 7 → exactly one FAIL pulse between edges 6 and 7, PASS_COUNT=2, FAIL_COUNT=1.
- DELAY=2. A=1 at edge 2 with EN=1, then EN=0 and A=1 at edge 3, C=0 on edges 4 and 5 → exactly one failure (edge 4); the A at edge 3 is ignored.
- CNT_WIDTH=2. Seven consecutive misses → FAIL_COUNT saturates at 3, FAIL pulses 7 times. CLR asserted on the edge of an eighth miss → all outputs 0, no FAIL pulse.
- ASYNCRESET asserted between edges while 2 obligations are in flight (DELAY=4) → outputs go to 0 immediately. No FAIL appears after release even with C=0. TS restarts so that a new miss reports FIRST_FAIL_TS relative to 0.
